// File: rtl/rng_pkg.sv
// -----------------------------------------------------------------------------
// rng_pkg
// Shared constants and the LFSR next-state function for the buffered LFSR
// random number generator.
//   LFSR_W       : LFSR state width (32)
//   TAP_*        : Fibonacci tap positions for x^32+x^22+x^2+x+1
//   DEFAULT_SEED : seed used when none (or a zero seed) is supplied
//   lfsr_step()  : one shift of the LFSR, returns the next state
// -----------------------------------------------------------------------------
package rng_pkg;

   localparam int LFSR_W = 32;
   localparam int TAP_A  = 31;
   localparam int TAP_B  = 21;
   localparam int TAP_C  = 1;
   localparam int TAP_D  = 0;

   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'h0000_0001;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      logic fb;
      fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
      return {s[LFSR_W-2:0], fb};
   endfunction

endpackage

// File: rtl/rng_fifo.sv
// -----------------------------------------------------------------------------
// rng_fifo
// Synchronous FIFO with show-ahead output used to buffer harvested words.
// Parameters: WIDTH (word width), DEPTH (entries, power of two >= 2).
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   flush       : discard all contents (takes priority over push/pop)
//   push, din   : write one word (ignored when full)
//   pop         : drop the head word (ignored when empty)
//   dout        : head word, 0 while empty
//   full, empty : occupancy flags
//   level       : number of stored words
// -----------------------------------------------------------------------------
module rng_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == LVL_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full & ~flush;
   assign pop_ok  = pop & ~empty & ~flush;

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Masking the head keeps the output at zero whenever nothing valid is stored.
   assign dout  = empty ? '0 : mem[rd_ptr];
   assign level = count;

endmodule

// File: rtl/buffered_lfsr_rng.sv
// -----------------------------------------------------------------------------
// buffered_lfsr_rng
// Free-running 32-bit Fibonacci LFSR that harvests one NUM_BITS-wide word
// every NUM_BITS generating cycles into a show-ahead FIFO, so bus reads are
// served back-to-back.  Optional health monitor under macro RNG_HEALTH_EN
// (repetition check on pushed words plus all-zero lockup detection).
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   enable       : generator / peripheral enable
//   dat_we       : reseed with dat_di (flushes FIFO, clears health alarm)
//   dat_re       : pop one word (ignored while dat_wait=1 or dat_we=1)
//   dat_di       : seed value
//   dat_do       : FIFO head word
//   dat_wait     : 1 when no word can be read
//   fill_level   : words currently buffered
//   health_fail  : sticky health alarm (constant 0 without RNG_HEALTH_EN)
// -----------------------------------------------------------------------------
module buffered_lfsr_rng
   import rng_pkg::*;
#(
   parameter int                NUM_BITS   = 32,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED,
   parameter int                REP_LIMIT  = 4,
   localparam int               LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                enable,
   input  logic                dat_we,
   input  logic                dat_re,
   input  logic [NUM_BITS-1:0] dat_di,
   output logic [NUM_BITS-1:0] dat_do,
   output logic                dat_wait,
   output logic [LVL_W-1:0]    fill_level,
   output logic                health_fail
);

   localparam int CNT_W = $clog2(NUM_BITS);

   if (NUM_BITS < 4 || NUM_BITS > 32 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REP_LIMIT < 2 || REP_LIMIT > 15 ||
       RESET_SEED == '0) begin : g_bad_param
      $error("buffered_lfsr_rng: illegal parameter value");
   end

   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] lfsr_nxt;
   logic [LFSR_W-1:0] seed_ext;
   logic [LFSR_W-1:0] seed_val;
   logic [CNT_W-1:0]  bit_cnt;
   logic              word_done;
   logic              fifo_full;
   logic              fifo_empty;
   logic              gen;
   logic              push;
   logic              pop;

   assign lfsr_nxt  = lfsr_step(lfsr);
   assign seed_ext  = LFSR_W'(dat_di);
   // A zero seed would lock the LFSR at zero forever.
   assign seed_val  = (seed_ext == '0) ? RESET_SEED : seed_ext;
   assign word_done = (bit_cnt == CNT_W'(NUM_BITS - 1));

   // Stalling on full makes the word sequence independent of read timing.
   assign gen      = enable & ~fifo_full & ~dat_we & ~health_fail;
   assign push     = gen & word_done;
   assign dat_wait = fifo_empty | ~enable | health_fail;
   assign pop      = dat_re & ~dat_wait & ~dat_we;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr    <= RESET_SEED;
         bit_cnt <= '0;
      end else if (dat_we) begin
         lfsr    <= seed_val;
         bit_cnt <= '0;
      end else if (gen) begin
         lfsr    <= lfsr_nxt;
         bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
      end
   end

   rng_fifo #(
      .WIDTH (NUM_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .flush  (dat_we),
      .push   (push),
      .pop    (pop),
      .din    (lfsr_nxt[NUM_BITS-1:0]),
      .dout   (dat_do),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fill_level)
   );

`ifdef RNG_HEALTH_EN
   logic [NUM_BITS-1:0] last_word;
   logic [3:0]          rep_cnt;
   logic                fail_q;

   always_ff @(posedge clk) begin
      if (push) last_word <= lfsr_nxt[NUM_BITS-1:0];
   end

   // rep_cnt == 0 means no word pushed since reset/reseed, so last_word is
   // not meaningful yet.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rep_cnt <= '0;
         fail_q  <= 1'b0;
      end else if (dat_we) begin
         rep_cnt <= '0;
         fail_q  <= 1'b0;
      end else begin
         if (lfsr == '0) fail_q <= 1'b1;
         if (push) begin
            if (rep_cnt != '0 && lfsr_nxt[NUM_BITS-1:0] == last_word) begin
               rep_cnt <= rep_cnt + 4'd1;
               if (rep_cnt == 4'(REP_LIMIT - 1)) fail_q <= 1'b1;
            end else begin
               rep_cnt <= 4'd1;
            end
         end
      end
   end

   assign health_fail = fail_q;
`else
   assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_buffered_lfsr_rng.sv
module tb_buffered_lfsr_rng;

   localparam int NB  = 8;
   localparam int DEP = 4;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         enable = 1'b0;
   logic         dat_we = 1'b0;
   logic         dat_re = 1'b0;
   logic [NB-1:0] dat_di = '0;
   logic [NB-1:0] dat_do;
   logic         dat_wait;
   logic [2:0]   fill_level;
   logic         health_fail;

   int checks = 0;
   int errors = 0;

   // Reference model: LFSR state, steps since last harvest, buffered words.
   logic [31:0]   m_state;
   int            m_phase;
   logic [NB-1:0] m_q[$];

   buffered_lfsr_rng #(
      .NUM_BITS   (NB),
      .FIFO_DEPTH (DEP),
      .RESET_SEED (32'h0000_0001),
      .REP_LIMIT  (4)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .enable      (enable),
      .dat_we      (dat_we),
      .dat_re      (dat_re),
      .dat_di      (dat_di),
      .dat_do      (dat_do),
      .dat_wait    (dat_wait),
      .fill_level  (fill_level),
      .health_fail (health_fail)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] poly_next(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input logic [31:0] seed);
      m_state = seed;
      m_phase = 0;
      m_q.delete();
   endtask

   // Applies the inputs present at this clock edge to the model.
   task automatic model_edge();
      int  sz;
      bit  waiting, do_pop, do_gen;
      sz      = m_q.size();
      waiting = (sz == 0) || !enable;
      do_pop  = dat_re && !waiting && !dat_we;
      do_gen  = enable && (sz < DEP) && !dat_we;
      if (dat_we) begin
         model_reset((dat_di == '0) ? 32'h1 : 32'(dat_di));
      end else begin
         if (do_pop) void'(m_q.pop_front());
         if (do_gen) begin
            m_state = poly_next(m_state);
            m_phase++;
            if (m_phase == NB) begin
               m_q.push_back(m_state[NB-1:0]);
               m_phase = 0;
            end
         end
      end
   endtask

   task automatic check_outputs();
      check("dat_wait", 32'(dat_wait), 32'((m_q.size() == 0) || !enable));
      check("fill_level", 32'(fill_level), 32'(m_q.size()));
      if (m_q.size() != 0) check("dat_do", 32'(dat_do), 32'(m_q[0]));
      check("health_fail", 32'(health_fail), 32'd0);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_do"},   32'(dat_do), 32'd0);
      check({tag, "_wait"}, 32'(dat_wait), 32'd1);
      check({tag, "_fill"}, 32'(fill_level), 32'd0);
      check({tag, "_hf"},   32'(health_fail), 32'd0);
   endtask

   initial begin
      // Reset state
      #1;
      check_reset_values("rst");
      model_reset(32'h1);
      @(negedge clk);
      resetn = 1'b1;
      enable = 1'b1;

      // First word 0xB6 pushed at edge 8, dat_wait falls in cycle 9
      repeat (7) cyc();
      check("first_wait_hi", 32'(dat_wait), 32'd1);
      cyc();
      check("first_word", 32'(dat_do), 32'hB6);
      check("first_wait_lo", 32'(dat_wait), 32'd0);

      // Fill up with no reads, then drain back-to-back
      repeat (100) cyc();
      check("full_level", 32'(fill_level), 32'd4);
      dat_re = 1'b1;
      repeat (4) cyc();
      dat_re = 1'b0;
      cyc();

      // Reseed with zero together with a read: flush wins, seed becomes 1
      dat_we = 1'b1;
      dat_re = 1'b1;
      dat_di = 8'h00;
      cyc();
      check("flush_level", 32'(fill_level), 32'd0);
      dat_we = 1'b0;
      dat_re = 1'b0;
      repeat (8) cyc();
      check("zero_seed_word", 32'(dat_do), 32'hB6);

      // Reseed with 0x5A and read randomly
      dat_we = 1'b1;
      dat_di = 8'h5A;
      cyc();
      dat_we = 1'b0;
      for (int i = 0; i < 40; i++) begin
         dat_re = 1'($urandom_range(0, 1));
         cyc();
      end
      dat_re = 1'b0;

      // Enable gap in the middle of a word
      repeat (3) cyc();
      enable = 1'b0;
      repeat (5) cyc();
      enable = 1'b1;
      repeat (20) cyc();

      // Asynchronous reset in the middle of a word, outputs without an edge
      repeat (3) cyc();
      #2;
      resetn = 1'b0;
      #1;
      check_reset_values("async_rst");
      model_reset(32'h1);
      @(negedge clk);
      resetn = 1'b1;
      repeat (12) cyc();

      // Randomized traffic: reads, enable gaps, occasional reseeds
      for (int i = 0; i < 500; i++) begin
         enable = ($urandom_range(0, 7) != 0);
         dat_re = 1'($urandom_range(0, 1));
         dat_we = ($urandom_range(0, 59) == 0);
         dat_di = 8'($urandom);
         cyc();
      end
      dat_we = 1'b0;
      dat_re = 1'b0;
      enable = 1'b1;
      repeat (10) cyc();

`ifdef RNG_HEALTH_EN
      // Lockup: force the LFSR to zero while the generator is idle
      enable = 1'b0;
      @(posedge clk);
      #1;
      dut.lfsr = '0;
      @(posedge clk);
      #1;
      check("lock_hf", 32'(health_fail), 32'd1);
      check("lock_wait", 32'(dat_wait), 32'd1);
      enable = 1'b1;
      dat_we = 1'b1;
      dat_di = 8'h01;
      @(posedge clk);
      model_reset(32'h1);
      #1;
      check("reseed_hf", 32'(health_fail), 32'd0);
      dat_we = 1'b0;
      repeat (8) cyc();
      check("recover_word", 32'(dat_do), 32'hB6);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
